e_mdu_iter: RTL and testbench
=============================

// Module: e_mdu_iter
// PURPOSE
//  Parametrised multiply/divide unit for the E stage, successor to the fixed 32-bit MDU.
//  Adds generic width, an iterative multi-bit-per-cycle divider, MADD/MSUB accumulation,
//  defined divide-by-zero results, a Done pulse, and abort-on-Req that leaves HI/LO intact.
//  It owns the architectural HI/LO registers. The hazard unit stalls on Busy.
// PARAMETERS
//  WIDTH    32  operand/HI/LO width; must be even and >= 8
//  MUL_LAT  5   cycles Busy stays high for the mult/madd/msub family; must be >= 1
//  DIV_BPC  4   quotient bits per divider iteration; one of 1, 2 or 4; WIDTH % DIV_BPC == 0
// PORTS
//  clk    in   1      clock; all state updates on the rising edge
//  reset  in   1      asynchronous, active-low reset (0 = in reset)
//  Req    in   1      exception/interrupt request; aborts an in-flight op and blocks accept
//  MDUOp  in   4      0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                     7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NONE
//  D1     in   WIDTH  rs operand: dividend / multiplicand / MTHI-MTLO data
//  D2     in   WIDTH  rt operand: divisor / multiplier
//  Start  in   1      qualifies MDUOp for this cycle
//  Busy   out  1      operation in flight
//  Done   out  1      1-cycle pulse in the cycle after HI/LO take a mul/div result
//  HI     out  WIDTH  HI register
//  LO     out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; Busy=0, Done=0, HI=0, LO=0; internal regs 0.
//  Accept: Start && !Req && !Busy && MDUOp in 1..10. Otherwise ignored; Start while Busy is dropped.
//  MTHI/MTLO: on the accept edge, HI<=D1 / LO<=D1. Busy stays 0 and Done stays 0.
//  FSM states: IDLE, MUL, DIV, FIX.
//   IDLE -> MUL on a mul-family accept: latch the product (signed or unsigned) and HI/LO;
//     count = MUL_LAT-1.
//   MUL: count decrements. At count==0, write HI/LO and go to IDLE.
//     Busy is high for exactly MUL_LAT cycles.
//   IDLE -> DIV on a div accept: latch |D1| and |D2| (signed) or raw (unsigned) values
//     and the sign flags; iter = WIDTH/DIV_BPC.
//   DIV: restoring division, DIV_BPC quotient bits per cycle, MSB first. After the last
//     iteration go to FIX.
//   FIX: apply signs and write HI/LO, then go to IDLE.
//     Busy is high for WIDTH/DIV_BPC+1 cycles (default 9).
//  Arithmetic (results wrap modulo 2^(2*WIDTH)):
//   MULT/MULTU: {HI,LO} = D1*D2, full 2*WIDTH-bit product.
//   MADD(U): {HI,LO} += product. MSUB(U): {HI,LO} -= product.
//     HI/LO operands are the values at accept; they cannot change while Busy.
//   DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//     MIN/-1 gives LO=MIN, HI=0.
//   DIVU: unsigned quotient and remainder.
//   Divide by zero (either kind): LO = all ones, HI = D1. Latency is unchanged.
//  Done: registered; high for 1 cycle after the HI/LO result write edge.
//  Abort: Req=1 while Busy -> next edge goes to IDLE with Busy=0 and Done=0.
//    HI/LO keep their pre-op values. Req wins over a same-cycle completion.
//  Req=1 in IDLE: no accept, and MTHI/MTLO are also suppressed.
//  Busy=0 in the completion cycle's next state: a new op is accepted the cycle after Busy falls.
//  Mid-op async reset: immediate return to reset values; no partial HI/LO write.
// TESTING
//  1. MULT D1=-3, D2=7 -> Busy high 5 cycles; HI=FFFFFFFF, LO=FFFFFFEB; Done pulses once.
//  2. DIV D1=-7, D2=2 -> Busy high 9 cycles; LO=FFFFFFFD (-3), HI=FFFFFFFF (-1).
//     DIVU 7/2 -> LO=3, HI=1.
//  3. DIVU D1=0x1234, D2=0 -> LO=FFFFFFFF, HI=00001234.
//     DIV 0x80000000 / FFFFFFFF -> LO=80000000, HI=0.
//  4. MTHI 5, MTLO FFFFFFFF, then MADDU 1*1 -> HI=6, LO=0.
//     Then MSUB 1*1 -> HI=5, LO=FFFFFFFF.
//  5. Start DIV with HI=AA, LO=BB; pulse Req on cycle 4 -> Busy falls next edge;
//     HI=AA, LO=BB; Done stays 0.
//  6. WIDTH=16, DIV_BPC=1, DIVU 0xFFFF/3 -> Busy high 17 cycles, LO=5555, HI=0;
//     Start asserted while Busy -> ignored.

Source files
------------

// File: rtl/e_mdu_iter_if.sv
// Bus between the E stage and the multiply/divide unit: operation request in,
// Busy/Done status and the architectural HI/LO registers out.
interface e_mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             Req;
  logic [3:0]       MDUOp;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Req, MDUOp, D1, D2, Start, input Busy, Done, HI, LO);
  modport slave  (input Req, MDUOp, D1, D2, Start, output Busy, Done, HI, LO);
endinterface

// File: rtl/e_mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply family and
// an MSB-first restoring divider retiring DIV_BPC quotient bits per cycle.
module e_mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_BPC = 4
) (
  input logic         clk,
  input logic         reset,
  e_mdu_iter_if.slave bus
);

  localparam int ITERS   = WIDTH / DIV_BPC;
  localparam int CNT_MAX = (ITERS > MUL_LAT) ? ITERS : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dnd_q, dnd_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  op_e                op;
  logic               mul_signed;
  logic [2*WIDTH-1:0] prod;
  logic               d1_neg, d2_neg;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH:0]     trial;

  assign op = op_e'(bus.MDUOp);

  // One shared multiplier: signedness only changes the operand extension.
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  assign prod = {{WIDTH{mul_signed & bus.D1[WIDTH-1]}}, bus.D1}
              * {{WIDTH{mul_signed & bus.D2[WIDTH-1]}}, bus.D2};

  assign d1_neg = (op == OP_DIV) && bus.D1[WIDTH-1];
  assign d2_neg = (op == OP_DIV) && bus.D2[WIDTH-1];

  // Dividend bits shift out of the top of quo while quotient bits enter at the bottom.
  always_comb begin
    rem_step = rem_q;
    quo_step = quo_q;
    trial    = '0;
    for (int b = 0; b < DIV_BPC; b++) begin
      trial    = {rem_step, quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial       = trial - {1'b0, dvs_q};
        quo_step[0] = 1'b1;
      end
      rem_step = trial[WIDTH-1:0];
    end
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    res_d   = res_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dnd_d   = dnd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Req) begin
          case (op)
            OP_MTHI: hi_d = bus.D1;
            OP_MTLO: lo_d = bus.D1;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              if (op == OP_MADD || op == OP_MADDU)      res_d = {hi_q, lo_q} + prod;
              else if (op == OP_MSUB || op == OP_MSUBU) res_d = {hi_q, lo_q} - prod;
              else                                      res_d = prod;
              cnt_d   = CW'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              quo_d   = d1_neg ? -bus.D1 : bus.D1;
              dvs_d   = d2_neg ? -bus.D2 : bus.D2;
              rem_d   = '0;
              qneg_d  = d1_neg ^ d2_neg;
              rneg_d  = d1_neg;
              dz_d    = (bus.D2 == '0);
              dnd_d   = bus.D1;
              cnt_d   = CW'(ITERS);
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (bus.Req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = res_q;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DIV: begin
        if (bus.Req) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (bus.Req) begin
          state_d = S_IDLE;
        end else begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = dnd_q;
          end else begin
            lo_d = qneg_q ? -quo_q : quo_q;
            hi_d = rneg_q ? -rem_q : rem_q;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dnd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dnd_q   <= dnd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_e_mdu_iter.sv
// Bench for e_mdu_iter: directed vector table, abort/back-to-back/reset sequences,
// and random ops against an arithmetic reference model; also a 16-bit 1-bit/cycle instance.
module tb_e_mdu_iter;

  localparam int WIN = 24;

  logic clk;
  logic reset;

  e_mdu_iter_if #(.WIDTH(32)) b32 ();
  e_mdu_iter_if #(.WIDTH(16)) b16 ();

  e_mdu_iter #(.WIDTH(32), .MUL_LAT(5), .DIV_BPC(4)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  e_mdu_iter #(.WIDTH(16), .MUL_LAT(5), .DIV_BPC(1)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
    int          done;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: the HI/LO pair an op leaves behind, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     sp, up, acc;
    sa  = longint'($signed(d1));
    sb  = longint'($signed(d2));
    ua  = {32'd0, d1};
    ub  = {32'd0, d2};
    sp  = 64'(sa * sb);
    up  = ua * ub;
    acc = {hi, lo};
    case (op)
      4'd1:  return sp;
      4'd2:  return up;
      4'd3: begin
        if (d2 == 32'd0) return {d1, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (d2 == 32'd0) return {d1, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      4'd5:  return {d1, lo};
      4'd6:  return {hi, d1};
      4'd7:  return acc + sp;
      4'd8:  return acc + up;
      4'd9:  return acc - sp;
      4'd10: return acc - up;
      default: return acc;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (op == 4'd3 || op == 4'd4) return 9;
    if (op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10)) return 5;
    return 0;
  endfunction

  // Issue one op to the 32-bit unit, then observe a fixed window of cycles.
  task automatic run32(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       output int busy_n, output int done_n);
    @(negedge clk);
    b32.Start = 1'b1; b32.MDUOp = op; b32.D1 = d1; b32.D2 = d2;
    @(negedge clk);
    b32.Start = 1'b0; b32.MDUOp = 4'd0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < WIN; i++) begin
      if (b32.Busy) busy_n++;
      if (b32.Done) done_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          busy_n, done_n, wait_n;
    logic [63:0] exp;
    logic [31:0] mhi, mlo, d1, d2;
    logic [3:0]  op;

    vecs[0]  = '{4'd1,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 1};
    vecs[1]  = '{4'd3,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 9, 1};
    vecs[2]  = '{4'd4,  32'd7,         32'd2,         32'd1,         32'd3,         9, 1};
    vecs[3]  = '{4'd4,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 9, 1};
    vecs[4]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 9, 1};
    vecs[5]  = '{4'd5,  32'd5,         32'd0,         32'd5,         32'h8000_0000, 0, 0};
    vecs[6]  = '{4'd6,  32'hFFFF_FFFF, 32'd0,         32'd5,         32'hFFFF_FFFF, 0, 0};
    vecs[7]  = '{4'd8,  32'd1,         32'd1,         32'd6,         32'd0,         5, 1};
    vecs[8]  = '{4'd9,  32'd1,         32'd1,         32'd5,         32'hFFFF_FFFF, 5, 1};
    vecs[9]  = '{4'd11, 32'd9,         32'd9,         32'd5,         32'hFFFF_FFFF, 0, 0};
    vecs[10] = '{4'd10, 32'd2,         32'd3,         32'd5,         32'hFFFF_FFF9, 5, 1};

    reset = 1'b0;
    b32.Req = 1'b0; b32.Start = 1'b0; b32.MDUOp = 4'd0; b32.D1 = '0; b32.D2 = '0;
    b16.Req = 1'b0; b16.Start = 1'b0; b16.MDUOp = 4'd0; b16.D1 = '0; b16.D2 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(b32.Busy), 64'd0);
    check("reset_done", 64'(b32.Done), 64'd0);
    check("reset_hilo", {b32.HI, b32.LO}, 64'd0);
    reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run32(vecs[v].op, vecs[v].d1, vecs[v].d2, busy_n, done_n);
      check($sformatf("vec%0d_hi", v), 64'(b32.HI), 64'(vecs[v].hi));
      check($sformatf("vec%0d_lo", v), 64'(b32.LO), 64'(vecs[v].lo));
      check($sformatf("vec%0d_busy", v), 64'(busy_n), 64'(vecs[v].busy));
      check($sformatf("vec%0d_done", v), 64'(done_n), 64'(vecs[v].done));
    end

    // Abort a divide in its fourth busy cycle.
    run32(4'd5, 32'hAA, 32'd0, busy_n, done_n);
    run32(4'd6, 32'hBB, 32'd0, busy_n, done_n);
    @(negedge clk);
    b32.Start = 1'b1; b32.MDUOp = 4'd3; b32.D1 = 32'd100; b32.D2 = 32'd7;
    @(negedge clk);
    b32.Start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(b32.Busy), 64'd1);
    b32.Req = 1'b1;
    @(negedge clk);
    b32.Req = 1'b0;
    check("abort_busy_after", 64'(b32.Busy), 64'd0);
    check("abort_hilo", {b32.HI, b32.LO}, {32'hAA, 32'hBB});
    check("abort_done0", 64'(b32.Done), 64'd0);
    @(negedge clk);
    check("abort_done1", 64'(b32.Done), 64'd0);

    // Req in IDLE blocks MTHI.
    b32.Req = 1'b1; b32.Start = 1'b1; b32.MDUOp = 4'd5; b32.D1 = 32'h123;
    @(negedge clk);
    b32.Req = 1'b0; b32.Start = 1'b0;
    check("req_idle_hi", 64'(b32.HI), 64'hAA);

    // Req coinciding with the multiply completion cycle wins.
    b32.Start = 1'b1; b32.MDUOp = 4'd1; b32.D1 = 32'd2; b32.D2 = 32'd3;
    @(negedge clk);
    b32.Start = 1'b0;
    repeat (4) @(negedge clk);
    b32.Req = 1'b1;
    @(negedge clk);
    b32.Req = 1'b0;
    check("req_last_busy", 64'(b32.Busy), 64'd0);
    check("req_last_hilo", {b32.HI, b32.LO}, {32'hAA, 32'hBB});
    check("req_last_done", 64'(b32.Done), 64'd0);

    // Back-to-back: a new op is accepted in the first cycle Busy is low.
    b32.Start = 1'b1; b32.MDUOp = 4'd2; b32.D1 = 32'd3; b32.D2 = 32'd4;
    @(negedge clk);
    b32.Start = 1'b0;
    wait_n = 0;
    while (b32.Busy && wait_n < 40) begin
      wait_n++;
      @(negedge clk);
    end
    check("b2b_first_latency", 64'(wait_n), 64'd5);
    check("b2b_first_lo", 64'(b32.LO), 64'd12);
    b32.Start = 1'b1; b32.MDUOp = 4'd2; b32.D1 = 32'd5; b32.D2 = 32'd6;
    @(negedge clk);
    b32.Start = 1'b0;
    check("b2b_second_busy", 64'(b32.Busy), 64'd1);
    repeat (6) @(negedge clk);
    check("b2b_second_lo", 64'(b32.LO), 64'd30);

    // Random ops against the reference model.
    run32(4'd5, 32'd0, 32'd0, busy_n, done_n);
    run32(4'd6, 32'd0, 32'd0, busy_n, done_n);
    mhi = 32'd0;
    mlo = 32'd0;
    for (int t = 0; t < 150; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
      case ($urandom_range(0, 7))
        0:       begin d1 = $urandom; d2 = 32'd0; end
        1:       begin d1 = 32'h8000_0000; d2 = 32'hFFFF_FFFF; end
        2:       begin d1 = $urandom_range(0, 300); d2 = $urandom_range(1, 20); end
        3:       begin d1 = -$urandom_range(0, 300); d2 = $urandom_range(1, 20); end
        default: begin d1 = $urandom; d2 = $urandom; end
      endcase
      exp = model(op, d1, d2, mhi, mlo);
      run32(op, d1, d2, busy_n, done_n);
      check($sformatf("rnd%0d_op%0d_hilo", t, op), {b32.HI, b32.LO}, exp);
      check($sformatf("rnd%0d_op%0d_busy", t, op), 64'(busy_n), 64'(latency(op)));
      check($sformatf("rnd%0d_op%0d_done", t, op), 64'(done_n), 64'(latency(op) > 0));
      {mhi, mlo} = exp;
    end

    // 16-bit, 1 bit/cycle divider; Start while Busy must be dropped.
    @(negedge clk);
    b16.Start = 1'b1; b16.MDUOp = 4'd4; b16.D1 = 16'hFFFF; b16.D2 = 16'd3;
    @(negedge clk);
    b16.Start = 1'b0; b16.MDUOp = 4'd0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (b16.Busy) busy_n++;
      if (b16.Done) done_n++;
      if (i == 5) begin
        b16.Start = 1'b1; b16.MDUOp = 4'd5; b16.D1 = 16'h1111;
      end else if (i == 6) begin
        b16.Start = 1'b0; b16.MDUOp = 4'd0;
      end
      @(negedge clk);
    end
    check("w16_busy", 64'(busy_n), 64'd17);
    check("w16_done", 64'(done_n), 64'd1);
    check("w16_lo", 64'(b16.LO), 64'h5555);
    check("w16_hi", 64'(b16.HI), 64'h0000);

    // Async reset mid-op: immediate clear, and no late HI/LO write afterwards.
    run32(4'd5, 32'h77, 32'd0, busy_n, done_n);
    @(negedge clk);
    b32.Start = 1'b1; b32.MDUOp = 4'd1; b32.D1 = 32'd9; b32.D2 = 32'd9;
    @(negedge clk);
    b32.Start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy", 64'(b32.Busy), 64'd0);
    check("midreset_hilo", {b32.HI, b32.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("postreset_hilo", {b32.HI, b32.LO}, 64'd0);
    check("postreset_done", 64'(b32.Done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
